// File: rtl/wb_spi_slave.sv
// Wishbone-mapped SPI mode-0 target with RX/TX byte buffers and a level interrupt.
// SPI pins are resynchronised to clk; sclk must run at clk/8 or slower.
module wb_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;

  logic        ack_q, intr_q, intr_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, enable_q, enable_d;
  logic [7:0]  rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_byte;
  logic        rx_full_q, rx_full_d, tx_full_q, tx_full_d;
  logic        overrun_q, overrun_d, underrun_q, underrun_d;
  logic        pend_q, pend_d, in_frame_q, in_frame_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;

  logic req, rd_rx, wr_tx, wr_st, wr_ctrl;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall, byte_done;

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign rd_rx   = req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign wr_tx   = req &  wb_we_i & (wb_adr_i[3:2] == 2'd1);
  assign wr_st   = req &  wb_we_i & (wb_adr_i[3:2] == 2'd2);
  assign wr_ctrl = req &  wb_we_i & (wb_adr_i[3:2] == 2'd3);

  // Frame activity is tracked by in_frame_q so a frame cut by reset stays ignored until ss falls.
  assign ss_fall   = enable_q & ss_prev_q & ~ss_s;
  assign ss_rise   = in_frame_q & ss_s;
  assign sclk_rise = in_frame_q & ~ss_s & sclk_s & ~sclk_prev_q;
  assign sclk_fall = in_frame_q & ~ss_s & ~sclk_s & sclk_prev_q;
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};

  always_comb begin
    case (wb_adr_i[3:2])
      2'd0:    rdata = {24'd0, rx_data_q};
      2'd1:    rdata = 32'd0;
      2'd2:    rdata = {27'd0, underrun_q, in_frame_q, overrun_q, tx_full_q, rx_full_q};
      default: rdata = {29'd0, enable_q, tx_ie_q, rx_ie_q};
    endcase
  end

  always_comb begin
    dat_d      = (req & ~wb_we_i) ? rdata : 32'd0;
    rx_ie_d    = wr_ctrl ? wb_dat_i[0] : rx_ie_q;
    tx_ie_d    = wr_ctrl ? wb_dat_i[1] : tx_ie_q;
    enable_d   = wr_ctrl ? wb_dat_i[2] : enable_q;
    rx_data_d  = rx_data_q;
    tx_buf_d   = tx_buf_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_full_d  = rx_full_q & ~rd_rx;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q & ~(wr_st & wb_dat_i[2]);
    underrun_d = underrun_q & ~(wr_st & wb_dat_i[4]);
    pend_d     = pend_q;
    in_frame_d = in_frame_q;
    bit_cnt_d  = bit_cnt_q;

    if (sclk_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      // A fill byte loaded at a byte boundary only counts as underrun once it is clocked out.
      if (pend_q) begin
        underrun_d = 1'b1;
        pend_d     = 1'b0;
      end
    end
    if (byte_done) begin
      if (rx_full_q & ~rd_rx) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d = rx_byte;
        rx_full_d = 1'b1;
      end
    end
    if (sclk_fall && bit_cnt_q != 3'd0) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
    if (ss_fall || byte_done) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = FILL_BYTE;
        if (ss_fall) underrun_d = 1'b1;
        else         pend_d     = 1'b1;
      end
    end
    if (wr_tx) begin
      tx_buf_d  = wb_dat_i[7:0];
      tx_full_d = 1'b1;
    end
    if (ss_fall) begin
      bit_cnt_d  = 3'd0;
      in_frame_d = 1'b1;
    end
    if (ss_rise || !enable_q) begin
      bit_cnt_d  = 3'd0;
      in_frame_d = 1'b0;
      pend_d     = 1'b0;
    end

    intr_d = (rx_ie_q & rx_full_q) | (tx_ie_q & ~tx_full_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      intr_q      <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      enable_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      tx_buf_q    <= 8'd0;
      rx_shift_q  <= 8'd0;
      tx_shift_q  <= 8'd0;
      rx_full_q   <= 1'b0;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      pend_q      <= 1'b0;
      in_frame_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      ack_q       <= req;
      dat_q       <= dat_d;
      intr_q      <= intr_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      enable_q    <= enable_d;
      rx_data_q   <= rx_data_d;
      tx_buf_q    <= tx_buf_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_full_q   <= rx_full_d;
      tx_full_q   <= tx_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      pend_q      <= pend_d;
      in_frame_q  <= in_frame_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign intr        = intr_q;
  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = in_frame_q;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: register vector table plus SPI frame sequences,
// with expected read data and MISO bytes queued on a scoreboard.
module tb_wb_spi_slave;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [3:0]  wb_sel_i;
  logic        intr, spi_sclk, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;

  wb_spi_slave #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .intr(intr),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <scoreboard empty>", nm, act);
    end else begin
      chk(nm, act, exp_q.pop_front());
    end
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
    int t;
    @(negedge clk);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wb_ack_o && t < 8);
    if (!wb_ack_o) chk("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] rd;
    wb_access(adr, 1'b1, wd, rd);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    exp_q.push_back(exp);
    wb_access(adr, 1'b0, 32'd0, rd);
    sb_pop(nm, rd);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: MOSI set while sclk low, MISO sampled just before the rising edge.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      wait_clk(4);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clk(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] mo, input logic [7:0] exp_miso, input string nm);
    logic [7:0] mi;
    exp_q.push_back({24'd0, exp_miso});
    spi_ss_n = 1'b0;
    wait_clk(8);
    spi_byte(mo, 8, mi);
    wait_clk(8);
    spi_ss_n = 1'b1;
    wait_clk(8);
    sb_pop(nm, {24'd0, mi});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m1, m2;

    vecs[0] = '{32'h0, 1'b0, 32'h0,        32'h0, "rst_rxdata"};
    vecs[1] = '{32'h8, 1'b0, 32'h0,        32'h0, "rst_status"};
    vecs[2] = '{32'hC, 1'b0, 32'h0,        32'h0, "rst_ctrl"};
    vecs[3] = '{32'hC, 1'b1, 32'h3,        32'h0, ""};
    vecs[4] = '{32'hC, 1'b0, 32'h0,        32'h3, "ctrl_rw"};
    vecs[5] = '{32'h4, 1'b1, 32'hA5,       32'h0, ""};
    vecs[6] = '{32'h4, 1'b0, 32'h0,        32'h0, "txdata_reads_0"};
    vecs[7] = '{32'h8, 1'b0, 32'h0,        32'h2, "status_tx_full"};
    vecs[8] = '{32'hC, 1'b1, 32'hFFFF_FFF4, 32'h0, ""};
    vecs[9] = '{32'hC, 1'b0, 32'h0,        32'h4, "ctrl_masked"};

    reset = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'hF;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(4);
    chk("rst_outputs", {wb_dat_o, wb_ack_o, intr, spi_miso, spi_miso_oe} == '0, 1'b1);
    reset = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wb_wr(vecs[i].adr, vecs[i].wdata);
      else            wb_rd(vecs[i].adr, vecs[i].exp, vecs[i].nm);
    end

    // 1: TXDATA=A5 and enable already set by the table
    spi_frame(8'h3C, 8'hA5, "t1_miso");
    wb_rd(32'h8, 32'h01, "t1_status");
    wb_rd(32'h0, 32'h3C, "t1_rxdata");

    // 2: overrun, then W1C
    spi_frame(8'h11, 8'hFF, "t2_miso0");
    spi_frame(8'h22, 8'hFF, "t2_miso1");
    wb_rd(32'h8, 32'h15, "t2_status");
    wb_wr(32'h8, 32'h04);
    wb_rd(32'h8, 32'h11, "t2_status_w1c");
    wb_rd(32'h0, 32'h11, "t2_rxdata");
    wb_wr(32'h8, 32'h10);
    wb_rd(32'h8, 32'h00, "t2_status_clr");

    // 3: underrun at ss fall; TXDATA written mid-byte goes out on the next byte
    spi_ss_n = 1'b0;
    wait_clk(8);
    fork
      spi_byte(8'hC3, 8, m1);
      begin
        wait_clk(20);
        wb_wr(32'h4, 32'h96);
      end
    join
    spi_byte(8'h3A, 8, m2);
    wait_clk(8);
    spi_ss_n = 1'b1;
    wait_clk(8);
    chk("t3_miso0", {24'd0, m1}, 32'hFF);
    chk("t3_miso1", {24'd0, m2}, 32'h96);
    wb_rd(32'h8, 32'h15, "t3_status");
    wb_rd(32'h0, 32'hC3, "t3_rxdata");
    wb_wr(32'h8, 32'h14);
    wb_rd(32'h8, 32'h00, "t3_status_clr");

    // 4: ss rises after 5 bits
    wb_wr(32'h4, 32'h42);
    spi_ss_n = 1'b0;
    wait_clk(8);
    spi_byte(8'hFF, 5, m1);
    wait_clk(8);
    spi_ss_n = 1'b1;
    wait_clk(8);
    chk("t4_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    wb_rd(32'h8, 32'h00, "t4_status");
    spi_frame(8'h81, 8'hFF, "t4_miso");
    wb_rd(32'h0, 32'h81, "t4_rxdata");
    wb_wr(32'h8, 32'h14);

    // 5: interrupt sources
    wb_wr(32'hC, 32'h7);
    wait_clk(2);
    chk("t5_intr_tx_empty", {31'd0, intr}, 32'd1);
    wb_wr(32'h4, 32'h55);
    wait_clk(2);
    chk("t5_intr_tx_full", {31'd0, intr}, 32'd0);
    spi_frame(8'h77, 8'h55, "t5_miso");
    wb_wr(32'h4, 32'h66);
    wait_clk(2);
    chk("t5_intr_rx_full", {31'd0, intr}, 32'd1);
    wb_rd(32'h0, 32'h77, "t5_rxdata");
    wait_clk(2);
    chk("t5_intr_cleared", {31'd0, intr}, 32'd0);

    // 6: reset mid-byte (0x66 goes out, miso shows bit 5 after two bits)
    spi_ss_n = 1'b0;
    wait_clk(8);
    spi_byte(8'hA0, 2, m1);
    wait_clk(6);
    chk("t6_pre_rst", {29'd0, intr, spi_miso, spi_miso_oe}, 32'h7);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    chk("t6_rst_outputs", {wb_dat_o, wb_ack_o, intr, spi_miso, spi_miso_oe} == '0, 1'b1);
    wb_wr(32'hC, 32'h4);
    spi_byte(8'hA0, 6, m1);
    wait_clk(8);
    spi_ss_n = 1'b1;
    wait_clk(8);
    wb_rd(32'h8, 32'h00, "t6_status");
    spi_frame(8'h5A, 8'hFF, "t6_miso");
    wb_rd(32'h0, 32'h5A, "t6_rxdata");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
